// File: rtl/mem_pkg.sv
// Shared encodings for the byte-wide RAM port sequencer: access sizes, FSM states, grant ids.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  // True when the access cannot be performed: bad size code or address not
  // aligned to the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = |lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Index of the final beat (beats - 1) for a legal size.
  function automatic logic [1:0] last_beat(input logic [1:0] size);
    case (size)
      SZ_HALF: last_beat = 2'd1;
      SZ_WORD: last_beat = 2'd3;
      default: last_beat = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb2.sv
// Two-way arbiter between instruction fetch and data memory requesters.
// Latency: combinational, grant valid in the same cycle as the requests.
// Backpressure: none; the loser simply keeps its request asserted.
import mem_pkg::*;

module mem_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic if_req,
  input  logic dm_req,
  input  gnt_t last_grant,
  output gnt_t grant,
  output logic any_req
);

  assign any_req = if_req | dm_req;

  // On a tie either alternate away from the previous winner or favour DM.
  always_comb begin
    grant = GNT_IF;
    if (if_req && dm_req) begin
      if (RR_EN) grant = (last_grant == GNT_IF) ? GNT_DM : GNT_IF;
      else       grant = GNT_DM;
    end else if (dm_req) begin
      grant = GNT_DM;
    end
  end

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one byte-wide RAM between fetch and data ports, splitting words into big-endian byte beats.
// Latency: done in cycle N+1 after the request cycle (N = 1/2/4 beats); errors report in cycle 1.
// Backpressure: requesters hold req until their done pulse; the ungranted port waits untouched.
import mem_pkg::*;

module mem_port_sequencer #(
  parameter int ADDR_W = 8,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy
);

  state_t            state;
  gnt_t              gnt;
  gnt_t              last_grant;
  gnt_t              grant;
  logic              any_req;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lastk_q;
  logic [1:0]        k;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [23:0]       acc;

  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic              sel_err;
  logic              in_xfer;
  logic [4:0]        bsel;
  logic [31:0]       rd_word;

  mem_arb2 #(.RR_EN(RR_EN)) u_arb (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_grant (last_grant),
    .grant      (grant),
    .any_req    (any_req)
  );

  // Present the winning port's request fields; fetches are always word reads.
  always_comb begin
    sel_size = SZ_WORD;
    sel_addr = if_addr;
    sel_we   = 1'b0;
    if (grant == GNT_DM) begin
      sel_size = dm_size;
      sel_addr = dm_addr;
      sel_we   = dm_we;
    end
  end

  assign sel_err = misaligned(sel_size, sel_addr[1:0]);

  // RAM beat signals decode straight from registered state. The write strobe is
  // also gated by clr so an aborting access cannot land one more byte.
  assign in_xfer   = (state == ST_XFER);
  assign ram_en    = in_xfer;
  assign ram_we    = in_xfer & we_q & ~clr;
  assign ram_addr  = addr_q + ADDR_W'(k);
  assign bsel      = {lastk_q - k, 3'b000};
  assign ram_wdata = wdata_q[bsel +: 8];
  assign busy      = (state != ST_IDLE);
  assign rd_word   = {acc, ram_rdata};

  // Sequencer FSM: grant and latch in IDLE, run byte beats in XFER, pulse done in DONE.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      gnt        <= GNT_IF;
      last_grant <= GNT_IF;
      addr_q     <= '0;
      lastk_q    <= 2'd0;
      k          <= 2'd0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      acc        <= '0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      dm_done    <= 1'b0;
      dm_err     <= 1'b0;
      dm_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      if_err  <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt        <= grant;
            last_grant <= grant;
            addr_q     <= sel_addr;
            lastk_q    <= last_beat(sel_size);
            we_q       <= sel_we;
            wdata_q    <= dm_wdata;
            k          <= 2'd0;
            acc        <= '0;
            if (sel_err) begin
              // Rejected access skips the RAM entirely and reports immediately.
              state <= ST_DONE;
              if (grant == GNT_IF) begin
                if_done  <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end else begin
                dm_done  <= 1'b1;
                dm_err   <= 1'b1;
                dm_rdata <= '0;
              end
            end else begin
              state <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          acc <= rd_word[23:0];
          k   <= k + 2'd1;
          if (k == lastk_q) begin
            state <= ST_DONE;
            if (gnt == GNT_IF) begin
              if_done  <= 1'b1;
              if_rdata <= rd_word;
            end else begin
              dm_done  <= 1'b1;
              dm_rdata <= we_q ? 32'd0 : rd_word;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
